// File: rtl/pdp8_pkg.sv
// Shared PDP-8 widths and the enumerated types used by the memory arbiter.
package pdp8_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  // EXEC slot payload layout: {is_wr, addr, wdata}
  localparam int EXEC_PAYLOAD_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_IFU,
    REQ_EXEC
  } requester_t;

endpackage

// File: rtl/req_slot.sv
// One-entry request holding register. A load while the slot is occupied is
// refused and flagged through ovf, unless the slot is being cleared in the
// same cycle, in which case the new request replaces the old one.
module req_slot #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             ovf
);

  assign ovf = load && valid && !clear;

  // Accept a new request when empty or being freed, otherwise drop it on clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load && (!valid || clear)) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single PDP-8 memory port between the
// instruction fetch unit and the execute unit. Each requester owns one
// holding slot; a four-state FSM issues the winner's access, waits out the
// fixed read latency and returns data or a write acknowledge.
module mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_valid,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_valid,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_ack,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  ovf_err
);

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  arb_state_t state, next_state;
  requester_t last_grant, grant_sel;
  logic       grant_en;
  logic       capture;
  logic [2:0] lat_cnt;

  logic                      ifu_valid, ifu_ovf, ifu_clear;
  logic [ADDR_WIDTH-1:0]     ifu_addr_q;
  logic                      exec_valid, exec_ovf, exec_clear, exec_load;
  logic [EXEC_PAYLOAD_W-1:0] exec_din, exec_q;
  logic                      exec_is_wr;
  logic [ADDR_WIDTH-1:0]     exec_addr_q;
  logic [DATA_WIDTH-1:0]     exec_wdata_q;

  // A simultaneous read and write from EXEC keeps the write; the read is lost.
  assign exec_load = exec_rd_req || exec_wr_req;
  assign exec_din  = exec_wr_req ? {1'b1, exec_wr_addr, exec_wr_data}
                                 : {1'b0, exec_rd_addr, {DATA_WIDTH{1'b0}}};

  assign exec_is_wr   = exec_q[EXEC_PAYLOAD_W-1];
  assign exec_addr_q  = exec_q[DATA_WIDTH +: ADDR_WIDTH];
  assign exec_wdata_q = exec_q[DATA_WIDTH-1:0];

  // Slots are freed in the response cycle of the transaction they fed.
  assign ifu_clear  = (state == RESP) && (last_grant == REQ_IFU);
  assign exec_clear = (state == RESP) && (last_grant == REQ_EXEC);

  req_slot #(.WIDTH(ADDR_WIDTH)) u_ifu_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ifu_rd_req),
    .clear   (ifu_clear),
    .din     (ifu_rd_addr),
    .valid   (ifu_valid),
    .dout    (ifu_addr_q),
    .ovf     (ifu_ovf)
  );

  req_slot #(.WIDTH(EXEC_PAYLOAD_W)) u_exec_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (exec_load),
    .clear   (exec_clear),
    .din     (exec_din),
    .valid   (exec_valid),
    .dout    (exec_q),
    .ovf     (exec_ovf)
  );

  // FSM state and the current grant owner; last_grant doubles as the winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= REQ_EXEC;
    end else begin
      state <= next_state;
      if (grant_en) last_grant <= grant_sel;
    end
  end

  // Next-state decode, arbitration and the one-cycle strobes/pulses.
  always_comb begin
    next_state    = state;
    grant_en      = 1'b0;
    grant_sel     = last_grant;
    capture       = 1'b0;
    mem_rd_req    = 1'b0;
    mem_wr_req    = 1'b0;
    ifu_rd_valid  = 1'b0;
    exec_rd_valid = 1'b0;
    exec_wr_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (ifu_valid || exec_valid) begin
          grant_en   = 1'b1;
          next_state = ISSUE;
          if (ifu_valid && exec_valid)
            grant_sel = (last_grant == REQ_IFU) ? REQ_EXEC : REQ_IFU;
          else if (ifu_valid)
            grant_sel = REQ_IFU;
          else
            grant_sel = REQ_EXEC;
        end
      end
      ISSUE: begin
        if ((last_grant == REQ_EXEC) && exec_is_wr) begin
          mem_wr_req = 1'b1;
          next_state = RESP;
        end else begin
          mem_rd_req = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == 3'd1) begin
          capture    = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (last_grant == REQ_IFU) ifu_rd_valid = 1'b1;
        else if (exec_is_wr)       exec_wr_ack  = 1'b1;
        else                       exec_rd_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latency counter: loaded when a read is issued, counts down while waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt <= '0;
    end else if (mem_rd_req) begin
      lat_cnt <= LAT_INIT;
    end else if (state == WAIT) begin
      lat_cnt <= lat_cnt - 3'd1;
    end
  end

  // Memory address/data are latched on grant so they hold between accesses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_en) begin
      if (grant_sel == REQ_IFU) begin
        mem_addr <= ifu_addr_q;
      end else begin
        mem_addr  <= exec_addr_q;
        mem_wdata <= exec_wdata_q;
      end
    end
  end

  // Read data is captured for the winner and held until its next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifu_rd_data  <= '0;
      exec_rd_data <= '0;
    end else if (capture) begin
      if (last_grant == REQ_IFU) ifu_rd_data  <= mem_rd_data;
      else                       exec_rd_data <= mem_rd_data;
    end
  end

  // Sticky flag for any dropped request; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_err <= 1'b0;
    end else if (ifu_ovf || exec_ovf || (exec_rd_req && exec_wr_req)) begin
      ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a registered-latency
// memory model. Each table row is one clock cycle of inputs and expected outputs.
module tb_mem_arbiter;
  import pdp8_pkg::*;

  localparam int RD_LAT = 3;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b1;
  logic                  ifu_rd_req = 1'b0;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr = '0;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  ifu_rd_valid;
  logic                  exec_rd_req = 1'b0;
  logic [ADDR_WIDTH-1:0] exec_rd_addr = '0;
  logic [DATA_WIDTH-1:0] exec_rd_data;
  logic                  exec_rd_valid;
  logic                  exec_wr_req = 1'b0;
  logic [ADDR_WIDTH-1:0] exec_wr_addr = '0;
  logic [DATA_WIDTH-1:0] exec_wr_data = '0;
  logic                  exec_wr_ack;
  logic                  mem_rd_req;
  logic                  mem_wr_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  ovf_err;

  int n_checks = 0;
  int n_pass   = 0;
  int row_idx  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ifu_rd_req    (ifu_rd_req),
    .ifu_rd_addr   (ifu_rd_addr),
    .ifu_rd_data   (ifu_rd_data),
    .ifu_rd_valid  (ifu_rd_valid),
    .exec_rd_req   (exec_rd_req),
    .exec_rd_addr  (exec_rd_addr),
    .exec_rd_data  (exec_rd_data),
    .exec_rd_valid (exec_rd_valid),
    .exec_wr_req   (exec_wr_req),
    .exec_wr_addr  (exec_wr_addr),
    .exec_wr_data  (exec_wr_data),
    .exec_wr_ack   (exec_wr_ack),
    .mem_rd_req    (mem_rd_req),
    .mem_wr_req    (mem_wr_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rd_data   (mem_rd_data),
    .ovf_err       (ovf_err)
  );

  // Memory model: data shows up RD_LAT cycles after the read strobe, for one cycle only.
  logic [11:0] mem     [0:4095];
  logic [11:0] rd_pipe [0:RD_LAT-1];
  assign mem_rd_data = rd_pipe[RD_LAT-1];

  initial begin : memory_model
    for (int i = 0; i < 4096; i++) mem[i] <= 12'o0;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= 12'o0;
    mem[12'o0200] <= 12'o7200;
    mem[12'o0300] <= 12'o5300;
    mem[12'o0400] <= 12'o4400;
    forever begin
      @(posedge clk);
      if (mem_wr_req) mem[mem_addr] <= mem_wdata;
      rd_pipe[0] <= mem_rd_req ? mem[mem_addr] : 12'o0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  typedef struct packed {
    logic        ifu_req;
    logic [11:0] ifu_addr;
    logic        erd;
    logic [11:0] erd_addr;
    logic        ewr;
    logic [11:0] ewr_addr;
    logic [11:0] ewr_data;
    logic        mrd;
    logic        mwr;
    logic [11:0] maddr;
    logic [11:0] mwdata;
    logic        ifu_v;
    logic [11:0] ifu_d;
    logic        erd_v;
    logic [11:0] erd_d;
    logic        wack;
    logic        ovf;
    int          reps;
  } row_t;

  row_t tbl[$];

  function automatic row_t nop(int n);
    row_t r;
    r = '0;
    r.reps = n;
    return r;
  endfunction

  function automatic row_t exp_mrd(logic [11:0] a);
    row_t r;
    r = nop(1);
    r.mrd = 1'b1;
    r.maddr = a;
    return r;
  endfunction

  function automatic row_t exp_mwr(logic [11:0] a, logic [11:0] d);
    row_t r;
    r = nop(1);
    r.mwr = 1'b1;
    r.maddr = a;
    r.mwdata = d;
    return r;
  endfunction

  function automatic row_t exp_ifu(logic [11:0] d);
    row_t r;
    r = nop(1);
    r.ifu_v = 1'b1;
    r.ifu_d = d;
    return r;
  endfunction

  function automatic row_t exp_erd(logic [11:0] d);
    row_t r;
    r = nop(1);
    r.erd_v = 1'b1;
    r.erd_d = d;
    return r;
  endfunction

  function automatic row_t exp_wack();
    row_t r;
    r = nop(1);
    r.wack = 1'b1;
    return r;
  endfunction

  function automatic row_t add_ifu(row_t r, logic [11:0] a);
    r.ifu_req = 1'b1;
    r.ifu_addr = a;
    return r;
  endfunction

  function automatic row_t add_erd(row_t r, logic [11:0] a);
    r.erd = 1'b1;
    r.erd_addr = a;
    return r;
  endfunction

  function automatic row_t add_ewr(row_t r, logic [11:0] a, logic [11:0] d);
    r.ewr = 1'b1;
    r.ewr_addr = a;
    r.ewr_data = d;
    return r;
  endfunction

  function automatic row_t with_ovf(row_t r);
    r.ovf = 1'b1;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %o, expected %o", name, act, exp);
  endtask

  task automatic applyStimulus(input row_t r);
    @(posedge clk);
    #1;
    ifu_rd_req   = r.ifu_req;
    ifu_rd_addr  = r.ifu_addr;
    exec_rd_req  = r.erd;
    exec_rd_addr = r.erd_addr;
    exec_wr_req  = r.ewr;
    exec_wr_addr = r.ewr_addr;
    exec_wr_data = r.ewr_data;
  endtask

  task automatic checkOutput(input row_t r, input int idx);
    logic [11:0] act_s, exp_s;
    act_s = {6'b0, mem_rd_req, mem_wr_req, ifu_rd_valid, exec_rd_valid, exec_wr_ack, ovf_err};
    exp_s = {6'b0, r.mrd, r.mwr, r.ifu_v, r.erd_v, r.wack, r.ovf};
    checkVal($sformatf("row%0d strobes(rd,wr,ifu_v,erd_v,ack,ovf)", idx), act_s, exp_s);
    if (r.mrd || r.mwr) checkVal($sformatf("row%0d mem_addr", idx), mem_addr, r.maddr);
    if (r.mwr)          checkVal($sformatf("row%0d mem_wdata", idx), mem_wdata, r.mwdata);
    if (r.ifu_v)        checkVal($sformatf("row%0d ifu_rd_data", idx), ifu_rd_data, r.ifu_d);
    if (r.erd_v)        checkVal($sformatf("row%0d exec_rd_data", idx), exec_rd_data, r.erd_d);
  endtask

  task automatic runRow(input row_t r);
    for (int k = 0; k < r.reps; k++) begin
      applyStimulus(r);
      @(negedge clk);
      checkOutput(r, row_idx);
      row_idx++;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " strobes"}, {6'b0, mem_rd_req, mem_wr_req, ifu_rd_valid,
                                 exec_rd_valid, exec_wr_ack, ovf_err}, 12'o0);
    checkVal({tag, " mem_addr"}, mem_addr, 12'o0);
    checkVal({tag, " mem_wdata"}, mem_wdata, 12'o0);
    checkVal({tag, " ifu_rd_data"}, ifu_rd_data, 12'o0);
    checkVal({tag, " exec_rd_data"}, exec_rd_data, 12'o0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : main
    // Power-on reset with a real falling edge
    #2 reset_n = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Contention right after reset: last_grant is EXEC, so IFU goes first
    tbl.push_back(add_erd(add_ifu(nop(1), 12'o0300), 12'o0400));
    tbl.push_back(nop(1));
    tbl.push_back(exp_mrd(12'o0300));
    tbl.push_back(nop(RD_LAT));
    tbl.push_back(exp_ifu(12'o5300));
    tbl.push_back(nop(1));
    tbl.push_back(exp_mrd(12'o0400));
    tbl.push_back(nop(RD_LAT));
    tbl.push_back(exp_erd(12'o4400));
    tbl.push_back(nop(1));
    // Lone IFU read; a new pulse in its valid cycle is accepted without error
    tbl.push_back(add_ifu(nop(1), 12'o0200));
    tbl.push_back(nop(1));
    tbl.push_back(exp_mrd(12'o0200));
    tbl.push_back(nop(RD_LAT));
    tbl.push_back(add_ifu(exp_ifu(12'o7200), 12'o0300));
    tbl.push_back(nop(1));
    tbl.push_back(exp_mrd(12'o0300));
    tbl.push_back(nop(RD_LAT));
    tbl.push_back(exp_ifu(12'o5300));
    tbl.push_back(nop(1));
    // Contention with last_grant IFU: EXEC goes first this time
    tbl.push_back(add_erd(add_ifu(nop(1), 12'o0300), 12'o0400));
    tbl.push_back(nop(1));
    tbl.push_back(exp_mrd(12'o0400));
    tbl.push_back(nop(RD_LAT));
    tbl.push_back(exp_erd(12'o4400));
    tbl.push_back(nop(1));
    tbl.push_back(exp_mrd(12'o0300));
    tbl.push_back(nop(RD_LAT));
    tbl.push_back(exp_ifu(12'o5300));
    tbl.push_back(nop(1));
    // EXEC write then read back through memory
    tbl.push_back(add_ewr(nop(1), 12'o0050, 12'o1234));
    tbl.push_back(nop(1));
    tbl.push_back(exp_mwr(12'o0050, 12'o1234));
    tbl.push_back(exp_wack());
    tbl.push_back(nop(1));
    tbl.push_back(add_erd(nop(1), 12'o0050));
    tbl.push_back(nop(1));
    tbl.push_back(exp_mrd(12'o0050));
    tbl.push_back(nop(RD_LAT));
    tbl.push_back(exp_erd(12'o1234));
    tbl.push_back(nop(1));

    foreach (tbl[i]) runRow(tbl[i]);

    // Overflow: second IFU pulse while the slot is busy is dropped, ovf sticks
    runRow(add_ifu(nop(1), 12'o0200));
    runRow(nop(1));
    runRow(add_ifu(exp_mrd(12'o0200), 12'o0300));
    runRow(with_ovf(nop(RD_LAT)));
    runRow(with_ovf(exp_ifu(12'o7200)));
    runRow(with_ovf(nop(6)));

    // Collision: write wins, read dropped, only an ack comes back
    doReset();
    runRow(add_ewr(add_erd(nop(1), 12'o0400), 12'o0060, 12'o4321));
    runRow(with_ovf(nop(1)));
    runRow(with_ovf(exp_mwr(12'o0060, 12'o4321)));
    runRow(with_ovf(exp_wack()));
    runRow(with_ovf(nop(8)));

    // Reset in the middle of a read: everything clears, no late valid
    doReset();
    runRow(add_ifu(nop(1), 12'o0200));
    runRow(nop(1));
    runRow(exp_mrd(12'o0200));
    runRow(nop(1));
    #2 reset_n = 1'b0;
    #1 checkAllZero("mid-read reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    runRow(nop(8));
    runRow(add_ifu(nop(1), 12'o0300));
    runRow(nop(1));
    runRow(exp_mrd(12'o0300));
    runRow(nop(RD_LAT));
    runRow(exp_ifu(12'o5300));
    runRow(nop(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single PDP-8 memory port between the IFU (instruction fetch reads) and the EXEC unit (operand reads and writes).
- Holds one pending request per requester and grants the port round-robin between them.
- Drives the memory-side handshake, sequences the fixed read latency and returns data or acknowledge to the winning requester.
- Sits between IFD/EXEC and the memory model or controller. Memory read data is registered, arriving RD_LAT cycles after mem_rd_req.

Parameters:
RD_LAT, 1, memory read latency in cycles from the mem_rd_req cycle to valid mem_rd_data (1..7)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
ifu_rd_req  in  1  one-cycle pulse: fetch request
ifu_rd_addr  in  ADDR_WIDTH  fetch address, sampled with ifu_rd_req
ifu_rd_data  out  DATA_WIDTH  fetched word, valid with ifu_rd_valid
ifu_rd_valid  out  1  one-cycle pulse: fetch complete
exec_rd_req  in  1  one-cycle pulse: operand read request
exec_rd_addr  in  ADDR_WIDTH  read address, sampled with exec_rd_req
exec_rd_data  out  DATA_WIDTH  operand word, valid with exec_rd_valid
exec_rd_valid  out  1  one-cycle pulse: read complete
exec_wr_req  in  1  one-cycle pulse: write request
exec_wr_addr  in  ADDR_WIDTH  write address
exec_wr_data  in  DATA_WIDTH  write data
exec_wr_ack  out  1  one-cycle pulse: write complete
mem_rd_req  out  1  memory read strobe, one cycle
mem_wr_req  out  1  memory write strobe, one cycle
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rd_data  in  DATA_WIDTH  memory read data
ovf_err  out  1  sticky: request dropped (slot full or rd+wr collision)

Behaviour:
- Reset: asynchronous, active-low, honoured at any time including mid-transaction.
  - Clears all outputs, both slots, FSM state (IDLE), last_grant (EXEC) and latency counter.
  - An in-flight transaction is dropped silently; no valid or ack is produced.
- Slots:
  - IFU slot holds {valid, addr}. EXEC slot holds {valid, is_wr, addr, wdata}.
  - A request pulse loads its slot at the next edge.
  - A pulse while the slot is occupied is dropped and sets ovf_err.
  - Exception: a pulse in the cycle that slot's response (valid/ack) is issued is accepted.
  - exec_rd_req and exec_wr_req in the same cycle: the write is kept, the read is dropped and ovf_err is set.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any slot is valid, select a winner and go to ISSUE.
    - Only one slot valid: that slot wins.
    - Both valid: the requester not equal to last_grant wins.
    - last_grant updates on grant.
  - ISSUE (1 cycle): drive mem_addr and mem_wdata from the winner's slot.
    - Read: mem_rd_req=1, load lat_cnt=RD_LAT, go to WAIT.
    - Write: mem_wr_req=1, go to RESP.
  - WAIT: decrement lat_cnt. In the cycle lat_cnt==1, capture mem_rd_data into the winner's data register and go to RESP.
  - RESP (1 cycle): pulse ifu_rd_valid, exec_rd_valid or exec_wr_ack for the winner, clear the winner's slot, return to IDLE.
- Latency, pulse in cycle 0:
  - Read: mem_rd_req in cycle 2, valid in cycle 2+RD_LAT+1 (cycle 4 for RD_LAT=1).
  - Write: mem_wr_req in cycle 2, ack in cycle 3.
- Output holding:
  - mem_addr and mem_wdata hold their last value outside ISSUE.
  - rd_data outputs hold until the next capture for that requester.
- Strobes: at most one of mem_rd_req / mem_wr_req is high in any cycle. Valid and ack outputs never overlap.
- Width rules: DATA_WIDTH and ADDR_WIDTH are both 12. Data passes through unmodified.
- ovf_err clears only on reset.

Decomposition:
- pdp8_pkg provides ADDR_WIDTH and DATA_WIDTH.
- Add to pdp8_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}
  - requester_t enum {REQ_IFU, REQ_EXEC}
- Sub-module req_slot (one-entry holding register with valid, load, clear and overflow detect), instantiated for IFU and EXEC. The EXEC instance carries the extra is_wr and wdata fields via parameterised payload width.

Test Plan:
- IFU read alone: ifu_rd_req, addr 12'o0200, memory returns 12'o7200 → mem_rd_req in cycle 2 with mem_addr=12'o0200; ifu_rd_valid in cycle 4 with ifu_rd_data=12'o7200; ovf_err=0.
- EXEC write: addr 12'o0050, data 12'o1234 → mem_wr_req in cycle 2 with those values; exec_wr_ack in cycle 3; no read strobe.
- Contention: ifu_rd_req and exec_rd_req in the same cycle after reset → IFU granted first (mem_addr = IFU addr), EXEC second. Repeat the same pair → EXEC first this time (round-robin alternation).
- Overflow: two ifu_rd_req pulses two cycles apart (slot still occupied) → second dropped, ovf_err=1 and stays 1. A pulse in the ifu_rd_valid cycle is accepted with no error.
- Collision: exec_rd_req and exec_wr_req together → write performed, exec_wr_ack only, ovf_err=1.
- Reset mid-read: RD_LAT=3, assert reset_n=0 during WAIT → all outputs 0 immediately; no valid after release. A new request after reset completes normally in 3+RD_LAT cycles.
